addsub_seq: RTL and testbench

//   Parametrised multi-cycle two's-complement adder/subtractor for the ALU datapath.

---
 rtl/addsub_seq_if.sv | 33 +++
 rtl/addsub_seq.sv | 134 +++++++++++++
 tb/tb_addsub_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_if.sv
// Handshake and data bundle between the ALU control FSM and addsub_seq.
//   master : the requester (drives start, op_sub, a, b; receives result/flags)
//   slave  : the adder/subtractor block
// Signals:
//   start, op_sub, a, b        request side
//   ready, done                handshake status
//   sum, carryout, overflow,
//   zero, negative             result and flags, valid from the done pulse onward
interface addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, op_sub, a, b,
    input  ready, done, sum, carryout, overflow, zero, negative
  );

  modport slave (
    input  start, op_sub, a, b,
    output ready, done, sum, carryout, overflow, zero, negative
  );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor. Adds CHUNK bits per clock,
// LSB chunk first, rippling the carry between chunks through a register so a
// wide operation reuses one narrow adder slice.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    addsub_seq_if.slave: start/op_sub/a/b in; ready/done/sum/flags out
// A request is accepted on an edge with start && ready; done pulses for one
// cycle NCHUNK edges later. Result and flags only change on the edge that
// enters DONE.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic         clk,
  input logic         reset,
  addsub_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;          // already inverted for subtraction
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_work_q, sum_work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             msb_cin;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_work_d = sum_work_q;
    sum_d      = sum_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;

    a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
    b_chunk = b_q[cnt_q*CHUNK +: CHUNK];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // On the last chunk s_chunk[CHUNK-1] is result bit WIDTH-1, so the carry
    // into that bit falls out of the sum bit and the two operand bits.
    msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_chunk[CHUNK-1];

    case (state_q)
      S_RUN: begin
        sum_work_d[cnt_q*CHUNK +: CHUNK] = s_chunk;
        carry_d = c_chunk;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CHUNK) begin
          state_d    = S_DONE;
          sum_d      = sum_work_d;
          carryout_d = c_chunk;
          overflow_d = msb_cin ^ c_chunk;
          zero_d     = (sum_work_d == '0);
          negative_d = sum_work_d[WIDTH-1];
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
        if (state_q == S_DONE) state_d = S_IDLE;
        if (bus.start) begin
          state_d = S_RUN;
          a_d     = bus.a;
          b_d     = bus.op_sub ? ~bus.b : bus.b;
          carry_d = bus.op_sub;  // +1 completes the two's-complement negate
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_work_q <= '0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sum_work_q <= sum_work_d;
      sum_q      <= sum_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign bus.ready    = (state_q != S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.sum      = sum_q;
  assign bus.carryout = carryout_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;
endmodule

// File: tb/tb_addsub_seq.sv
module tb_addsub_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  addsub_seq_if #(.WIDTH(32)) bus32 ();
  addsub_seq_if #(.WIDTH(8))  bus8 ();

  addsub_seq #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  addsub_seq #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  // Issues one 32-bit op (start held for one edge), then waits for done.
  // Returns with the bench sitting #1 after the edge that raised done.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       output int lat);
    @(negedge clk);
    bus32.start = 1'b1; bus32.a = a; bus32.b = b; bus32.op_sub = sub;
    @(posedge clk); #1;
    bus32.start = 1'b0; bus32.a = '1; bus32.b = '1; bus32.op_sub = ~sub;
    lat = 0;
    while (bus32.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op32 a=%h b=%h sub=%0b -> sum=%h c=%0b v=%0b z=%0b n=%0b lat=%0d",
             a, b, sub, bus32.sum, bus32.carryout, bus32.overflow, bus32.zero,
             bus32.negative, lat);
  endtask

  task automatic chk_res(input string name, input int lat, input logic [31:0] s,
                         input logic c, input logic v, input logic z, input logic n);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL %s latency got %0d want 4", name, lat); end
    total++;
    if (bus32.sum !== s) begin bad++; $display("FAIL %s sum got %h want %h", name, bus32.sum, s); end
    total++;
    if ({bus32.carryout, bus32.overflow, bus32.zero, bus32.negative} !== {c, v, z, n}) begin
      bad++;
      $display("FAIL %s flags cvzn got %b want %b", name,
               {bus32.carryout, bus32.overflow, bus32.zero, bus32.negative}, {c, v, z, n});
    end
  endtask

  task automatic test_reset;
    bus32.start = 1'b1; bus32.a = 32'h1; bus32.b = 32'h1; bus32.op_sub = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op_sub = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("reset: ready=%0b done=%0b sum=%h", bus32.ready, bus32.done, bus32.sum);
    total++;
    if (bus32.ready !== 1'b1 || bus32.done !== 1'b0) begin
      bad++; $display("FAIL reset_hs got ready=%0b done=%0b want 1 0", bus32.ready, bus32.done);
    end
    total++;
    if ({bus32.sum, bus32.carryout, bus32.overflow, bus32.zero, bus32.negative} !== 36'h0) begin
      bad++; $display("FAIL reset_out got sum=%h want 0 with flags 0", bus32.sum);
    end
    bus32.start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_add;
    int lat;
    run32(32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    chk_res("t1_wrap", lat, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run32(32'h7FFF_FFFF, 32'h1, 1'b0, lat);
    chk_res("t2_ovf", lat, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_sub;
    int lat;
    run32(32'd5, 32'd7, 1'b1, lat);
    chk_res("t3_5m7", lat, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run32(32'd7, 32'd5, 1'b1, lat);
    chk_res("t3_7m5", lat, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    run32(32'h8000_0000, 32'h1, 1'b1, lat);
    chk_res("t4_minm1", lat, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run32(32'h0, 32'h0, 1'b1, lat);
    chk_res("t4_0m0", lat, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_and_abort;
    int lat;
    // Start 1+2, then pulse start with other operands mid-run.
    @(negedge clk);
    bus32.start = 1'b1; bus32.a = 32'd1; bus32.b = 32'd2; bus32.op_sub = 1'b0;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus32.ready !== 1'b0 || bus32.sum !== 32'h0) begin
      bad++; $display("FAIL t5_run_stable got ready=%0b sum=%h want 0 00000000", bus32.ready, bus32.sum);
    end
    bus32.start = 1'b1; bus32.a = 32'd100; bus32.b = 32'd100; bus32.op_sub = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    lat = 2;
    while (bus32.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    $display("t5 ignore: sum=%h lat=%0d", bus32.sum, lat);
    total++;
    if (lat !== 4 || bus32.sum !== 32'd3) begin
      bad++; $display("FAIL t5_ignore got sum=%h lat=%0d want 00000003 4", bus32.sum, lat);
    end
    // Abort after two chunks.
    @(negedge clk);
    bus32.start = 1'b1; bus32.a = 32'hFF; bus32.b = 32'hFF; bus32.op_sub = 1'b0;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("t5 abort: ready=%0b done=%0b sum=%h", bus32.ready, bus32.done, bus32.sum);
    total++;
    if (bus32.ready !== 1'b1 || bus32.done !== 1'b0 || bus32.sum !== 32'h0) begin
      bad++; $display("FAIL t5_abort got ready=%0b done=%0b sum=%h want 1 0 0", bus32.ready, bus32.done, bus32.sum);
    end
    repeat (5) begin
      @(posedge clk); #1;
      total++;
      if (bus32.done !== 1'b0) begin bad++; $display("FAIL t5_no_done got done=1 want 0"); end
    end
    run32(32'd3, 32'd4, 1'b0, lat);
    chk_res("t5_after", lat, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int lat;
    run32(32'd10, 32'd20, 1'b0, lat);
    chk_res("t6_first", lat, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    // Still in the DONE cycle: request the next op right away.
    bus32.start = 1'b1; bus32.a = 32'd100; bus32.b = 32'd1; bus32.op_sub = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    total++;
    if (bus32.ready !== 1'b0) begin bad++; $display("FAIL t6_no_gap got ready=%0b want 0", bus32.ready); end
    lat = 0;
    while (bus32.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    $display("t6 b2b: sum=%h lat=%0d", bus32.sum, lat);
    chk_res("t6_second", lat, 32'd99, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_chunk;
    int lat;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h7F; bus8.b = 8'h01; bus8.op_sub = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    $display("op8 7f+01 -> sum=%h c=%0b v=%0b z=%0b n=%0b lat=%0d", bus8.sum,
             bus8.carryout, bus8.overflow, bus8.zero, bus8.negative, lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL t6_w8_lat got %0d want 1", lat); end
    total++;
    if (bus8.sum !== 8'h80) begin bad++; $display("FAIL t6_w8_sum got %h want 80", bus8.sum); end
    total++;
    if ({bus8.carryout, bus8.overflow, bus8.zero, bus8.negative} !== 4'b0101) begin
      bad++; $display("FAIL t6_w8_flags got %b want 0101",
                      {bus8.carryout, bus8.overflow, bus8.zero, bus8.negative});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_and_abort();
    test_back_to_back();
    test_single_chunk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
